// File: rtl/sram_pkg.sv
// Common types, constants and the byte-lane merge helper for the SRAM responder.
package sram_pkg;
  import width_param::*;

  typedef enum logic {
    SRAM_INIT  = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

  localparam int NUM_OF_BYTES = 4;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_DEFAULT = 32'h1c00_0000;

  // Replace the bytes of old_word whose mask bit is set with those of new_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_word,
    input logic [DATA_WIDTH-1:0]   new_word,
    input logic [NUM_OF_BYTES-1:0] mask
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int b = 0; b < NUM_OF_BYTES; b++) begin
      if (mask[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction
endpackage

// File: rtl/width_param.sv
// Bus widths shared by the SRAM responder, its bank and its interface.
package width_param;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
endpackage

// File: rtl/sram_if.sv
// Read/write request bundle between an initiator and the SRAM responder.
interface sram_if;
  import width_param::*;
  import sram_pkg::*;

  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_OF_BYTES-1:0] wr_mask;

  // No handshake: a request is valid exactly in the cycle its enable is high
  // and is always accepted; read data appears one cycle later and then holds.
  modport s (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
    output rd_data
  );

  modport m (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
    input  rd_data
  );
endinterface

// File: rtl/sram_bank.sv
// Word-indexed storage with one byte-masked write port and one registered,
// write-first read port.
module sram_bank
  import width_param::*;
  import sram_pkg::*;
#(
  parameter int ADDR_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [ADDR_LOG2-1:0]    i_wr_idx,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [NUM_OF_BYTES-1:0] i_wr_mask,
  input  logic                    i_rd_en,
  input  logic                    i_rd_clr,
  input  logic [ADDR_LOG2-1:0]    i_rd_idx,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);
  localparam int DEPTH = 1 << ADDR_LOG2;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [NUM_OF_BYTES-1:0] w_bypass_mask;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // A same-word write is folded into the read so the reader sees the new bytes.
  always_comb begin
    w_bypass_mask = '0;
    if (i_wr_en && (i_wr_idx == i_rd_idx)) w_bypass_mask = i_wr_mask;
    w_rd_word = merge_bytes(r_mem[i_rd_idx], i_wr_data, w_bypass_mask);
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < NUM_OF_BYTES; b++) begin
        if (i_wr_mask[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_rd_word;
    end else if (i_rd_clr) begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sram_responder.sv
// Memory-mapped SRAM responder: clears its bank after reset, then serves
// byte-masked writes and one-cycle-latency reads inside a fixed address window.
module sram_responder
  import width_param::*;
  import sram_pkg::*;
#(
  parameter int                    ADDR_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  sram_if.s           sram_io,
  output logic        init_busy,
  output logic        addr_err,
  output sram_state_e o_dbg_state
);
  localparam int                   IDX_LSB    = 2;
  localparam int                   WIN_LSB    = ADDR_LOG2 + IDX_LSB;
  localparam logic [ADDR_LOG2-1:0] SWEEP_LAST = '1;

  sram_state_e             r_state;
  sram_state_e             w_state_nxt;
  logic [ADDR_LOG2-1:0]    r_sweep_idx;
  logic [ADDR_LOG2-1:0]    w_sweep_nxt;
  logic                    r_addr_err;
  logic                    w_addr_err_nxt;
  logic                    w_rd_in_win;
  logic                    w_wr_in_win;
  logic                    w_bank_wr_en;
  logic [ADDR_LOG2-1:0]    w_bank_wr_idx;
  logic [DATA_WIDTH-1:0]   w_bank_wr_data;
  logic [NUM_OF_BYTES-1:0] w_bank_wr_mask;
  logic                    w_bank_rd_en;
  logic                    w_bank_rd_clr;
  logic [ADDR_LOG2-1:0]    w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [3:0]              w_unused_addr_lsbs;

  assign w_rd_in_win = (sram_io.rd_addr[ADDR_WIDTH-1:WIN_LSB] == BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);
  assign w_wr_in_win = (sram_io.wr_addr[ADDR_WIDTH-1:WIN_LSB] == BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);
  assign w_rd_idx    = sram_io.rd_addr[WIN_LSB-1:IDX_LSB];
  assign w_unused_addr_lsbs = {sram_io.rd_addr[IDX_LSB-1:0], sram_io.wr_addr[IDX_LSB-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SRAM_INIT;
      r_sweep_idx <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
      r_addr_err  <= w_addr_err_nxt;
    end
  end

  // In INIT the bank write port is owned by the clear sweep and all
  // initiator traffic is dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_sweep_nxt    = r_sweep_idx;
    w_addr_err_nxt = 1'b0;
    w_bank_wr_en   = 1'b0;
    w_bank_wr_idx  = sram_io.wr_addr[WIN_LSB-1:IDX_LSB];
    w_bank_wr_data = sram_io.wr_data;
    w_bank_wr_mask = sram_io.wr_mask;
    w_bank_rd_en   = 1'b0;
    w_bank_rd_clr  = 1'b0;
    case (r_state)
      SRAM_INIT: begin
        w_bank_wr_en   = 1'b1;
        w_bank_wr_idx  = r_sweep_idx;
        w_bank_wr_data = '0;
        w_bank_wr_mask = '1;
        w_sweep_nxt    = r_sweep_idx + ADDR_LOG2'(1);
        if (r_sweep_idx == SWEEP_LAST) w_state_nxt = SRAM_READY;
      end
      SRAM_READY: begin
        w_bank_wr_en   = sram_io.wr_en && w_wr_in_win;
        w_bank_rd_en   = sram_io.rd_en && w_rd_in_win;
        w_bank_rd_clr  = sram_io.rd_en && !w_rd_in_win;
        w_addr_err_nxt = (sram_io.rd_en && !w_rd_in_win) || (sram_io.wr_en && !w_wr_in_win);
      end
      default: begin
        w_state_nxt = SRAM_INIT;
      end
    endcase
  end

  sram_bank #(
    .ADDR_LOG2 (ADDR_LOG2)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_bank_wr_en),
    .i_wr_idx  (w_bank_wr_idx),
    .i_wr_data (w_bank_wr_data),
    .i_wr_mask (w_bank_wr_mask),
    .i_rd_en   (w_bank_rd_en),
    .i_rd_clr  (w_bank_rd_clr),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign sram_io.rd_data = w_rd_data;
  assign init_busy       = (r_state == SRAM_INIT);
  assign addr_err        = r_addr_err;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder with a 16-word window.
module tb_sram_responder;
  import sram_pkg::*;

  localparam int          LOG2  = 4;
  localparam int          DEPTH = 1 << LOG2;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  logic        clk;
  logic        rst;
  logic        init_busy;
  logic        addr_err;
  sram_state_e dbg_state;

  sram_if sif();

  sram_responder #(
    .ADDR_LOG2 (LOG2),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sram_io     (sif),
    .init_busy   (init_busy),
    .addr_err    (addr_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd;
  int          init_left;
  logic [33:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("init_busy", {31'd0, init_busy}, {31'd0, e[33]});
        check("addr_err",  {31'd0, addr_err},  {31'd0, e[32]});
        check("rd_data",   sif.rd_data,        e[31:0]);
      end
    end
  end

  // driver: called at a negedge, applies one cycle of requests, returns at the next negedge
  task automatic tick(input logic rd, input logic [31:0] ra, input logic wr,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wm);
    bit err;
    sif.rd_en   = rd;
    sif.rd_addr = ra;
    sif.wr_en   = wr;
    sif.wr_addr = wa;
    sif.wr_data = wd;
    sif.wr_mask = wm;
    err = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else begin
      if (wr && in_window(wa)) begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) model_mem[word_of(wa)][8*b +: 8] = wd[8*b +: 8];
      end
      if (rd) last_rd = in_window(ra) ? model_mem[word_of(ra)] : 32'h0;
      err = (rd && !in_window(ra)) || (wr && !in_window(wa));
    end
    exp_q.push_back({(init_left > 0), err, last_rd});
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd_only(input logic [31:0] a);
    tick(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr_only(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    tick(1'b0, 32'h0, 1'b1, a, d, m);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_init_busy", {31'd0, init_busy}, 32'd1);
    check("rst_addr_err",  {31'd0, addr_err},  32'd0);
    check("rst_rd_data",   sif.rd_data,        32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    init_left = DEPTH;
    last_rd   = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'h1d00_0000;
      1:       a = BASE + 32'd64;
      2:       a = BASE - 32'd4;
      default: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic rand_tick();
    tick(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
         rand_addr(), $urandom(), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    sif.rd_en = 1'b0; sif.rd_addr = '0; sif.wr_en = 1'b0;
    sif.wr_addr = '0; sif.wr_data = '0; sif.wr_mask = '0;
    init_left = 0;
    last_rd   = 32'h0;
    @(negedge clk);

    // sweep interrupted at index 7, then a full sweep with traffic that must be ignored
    apply_reset();
    repeat (7) idle();
    apply_reset();
    repeat (DEPTH) rand_tick();

    rd_only(32'h1c00_0008);
    for (int i = 0; i < DEPTH; i++) rd_only(BASE + 32'(4 * i));

    // byte-masked overwrite, then read with data held while idle
    wr_only(32'h1c00_0004, 32'hAABB_CCDD, 4'b1111);
    wr_only(32'h1c00_0004, 32'h0000_1100, 4'b0010);
    rd_only(32'h1c00_0004);
    idle();
    idle();
    wr_only(32'h1c00_0004, 32'h1234_5678, 4'b0000);
    rd_only(32'h1c00_0007);

    // same-word write-first and different-word concurrent access
    wr_only(32'h1c00_0000, 32'h1122_3344, 4'b1111);
    tick(1'b1, 32'h1c00_0000, 1'b1, 32'h1c00_0000, 32'hFF00_0000, 4'b1000);
    tick(1'b1, 32'h1c00_0004, 1'b1, 32'h1c00_0008, 32'hCAFE_F00D, 4'b0101);
    rd_only(32'h1c00_0008);

    // out-of-window read and write, separately and together
    rd_only(32'h1d00_0000);
    idle();
    wr_only(32'h1d00_0000, 32'hDEAD_BEEF, 4'b1111);
    idle();
    rd_only(32'h1c00_0000);
    tick(1'b1, 32'h1c00_0040, 1'b1, 32'h1bff_fffc, 32'h5555_5555, 4'b1111);
    idle();
    rd_only(32'h1c00_003c);

    repeat (400) rand_tick();
    for (int i = 0; i < DEPTH; i++) rd_only(BASE + 32'(4 * i));
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_LOG2, default 12, word-index width; storage depth is 2^ADDR_LOG2 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h1c00_0000, byte address of word 0; must be aligned to 4*2^ADDR_LOG2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sram_io  sram_if.s  --  responder modport carrying the signals in REQ-006..REQ-012.
REQ-006 sram_rd_en  input  1  read request this cycle.
REQ-007 sram_rd_addr  input  32  word-aligned byte address; bits [1:0] ignored.
REQ-008 sram_rd_data  output  32  read result.
REQ-009 sram_wr_en  input  1  write request this cycle.
REQ-010 sram_wr_addr  input  32  word-aligned byte address; bits [1:0] ignored.
REQ-011 sram_wr_data  input  32  write data, lane-positioned by the initiator.
REQ-012 sram_wr_mask  input  4  byte enables; bit i enables byte [8i+7:8i].
REQ-013 init_busy  output  1  high while the post-reset clear sweep runs.
REQ-014 addr_err  output  1  one-cycle pulse for any request outside the mapped window.

Function
REQ-015 FSM states: INIT and READY; rst forces INIT with sweep counter 0.
REQ-016 INIT: zero one word per cycle at the counter index, counter +1; after index 2^ADDR_LOG2-1 is written, go to READY on the next edge; init_busy=1 throughout INIT.
REQ-017 INIT: rd_en/wr_en ignored (no storage change, rd_data holds 0, addr_err stays 0).
REQ-018 In-window check: addr[31:ADDR_LOG2+2] == BASE_ADDR[31:ADDR_LOG2+2]; word index = addr[ADDR_LOG2+1:2].
REQ-019 Write: in READY with wr_en=1 and in-window address, bytes with mask bit set update at the edge; unmasked bytes keep their value; mask 4'b0000 changes nothing.
REQ-020 Read latency is 1 cycle: rd_data presents the word registered at the edge where rd_en=1, in-window, READY.
REQ-021 rd_data holds its last value in cycles following rd_en=0.
REQ-022 Same-cycle read and write to the same word: write-first; rd_data equals the old word merged with the masked write bytes.
REQ-023 Same-cycle read and write to different words: both complete independently.
REQ-024 Out-of-window read: rd_data = 32'h0 next cycle and addr_err pulses; out-of-window write: storage unchanged and addr_err pulses; both in one cycle give a single pulse.
REQ-025 No backpressure: every READY request is accepted in the cycle presented.

Reset
REQ-026 On rst assertion, asynchronously: state=INIT, sweep counter=0, rd_data=0, addr_err=0, init_busy=1.
REQ-027 rst asserted mid-sweep restarts the sweep from index 0; rst asserted in READY discards any in-flight read result.
REQ-028 Storage array itself has no reset; clearing is done solely by the INIT sweep.

Structure
REQ-029 Shared package sram_pkg holds the state enum (SRAM_INIT, SRAM_READY), NUM_OF_BYTES=4 and BASE_ADDR default; DATA_WIDTH/ADDR_WIDTH come from width_param.sv.
REQ-030 One sub-module sram_bank: 2^ADDR_LOG2 x 32 array, one byte-masked write port, one registered read port, write-first bypass; FSM, window check and error logic stay in sram_responder.

Verification
REQ-031 Reset release, ADDR_LOG2=4 -> init_busy high exactly 16 cycles, then 0; read of 0x1c00_0008 returns 0.
REQ-032 Write 0x1c00_0004 data 0xAABBCCDD mask 1111, then write 0x1c00_0004 data 0x0000_1100 mask 0010 -> next read returns 0xAABB11DD one cycle after rd_en.
REQ-033 Same cycle read+write 0x1c00_0000, old 0x11223344, wr_data 0xFF000000 mask 1000 -> rd_data 0xFF223344.
REQ-034 Read 0x1d00_0000 -> rd_data 0, addr_err high one cycle; write there -> storage unchanged, addr_err pulses.
REQ-035 Assert rst at sweep index 7, release -> sweep restarts at 0, init_busy full length again; requests during INIT leave storage zero.
